// File: rtl/otl_pkg.sv
// Shared types and constants for the OTL FIFO write-port arbiter.
package otl_pkg;

  localparam int unsigned OTL_DATA_W = 32;
  localparam int unsigned OTL_STAT_W = 16;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } otl_state_e;

endpackage

// File: rtl/otl_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo N_REQ.
module otl_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic [N_REQ-1:0] req_rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;

  always_comb begin
    // Rotate so that bit 0 is the requester at ptr_i; lowest set bit is the winner's offset.
    req_rot = N_REQ'({req_i, req_i} >> ptr_i);
    off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
    idx_o = sum[ID_W-1:0];
    any_o = |req_i;
  end

endmodule

// File: rtl/otl_fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port with a registered write path.
// Define OTL_FIFO_WR_ARB_STATS_EN to add per-requester saturating word counters and stat_* ports.
module otl_fifo_wr_arb
  import otl_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ID_W      = 2
) (
  input  logic                        wr_clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [OTL_DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [OTL_DATA_W-1:0]       fifo_wr_data,
  output logic                        fifo_wr_en,
  input  logic                        fifo_almost_full,
  input  logic                        fifo_full,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  output logic                        overflow
`ifdef OTL_FIFO_WR_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]             stat_sel,
  input  logic                        stat_clr,
  output logic [OTL_STAT_W-1:0]       stat_count
`endif
);

  localparam logic [7:0] LastCnt = 8'(MAX_BURST - 1);

  otl_state_e              state_q, state_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [OTL_DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                    ovf_q, ovf_d;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_any;
  logic                    accept;
  logic                    gnt_valid;
  logic                    gnt_last;
  logic [OTL_DATA_W-1:0]   gnt_word;
  logic [ID_W-1:0]         ptr_next;

  otl_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) gnt_word = req_data[i*OTL_DATA_W +: OTL_DATA_W];
    end
    gnt_valid = req_valid[grant_q];
    gnt_last  = req_last[grant_q];
    ptr_next  = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q | (wr_en_q & fifo_full);
    req_ready = '0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any && !fifo_almost_full) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        req_ready[grant_q] = !fifo_almost_full;
        accept             = gnt_valid && !fifo_almost_full;
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = gnt_word;
          cnt_d     = cnt_q + 8'd1;
        end
        // Almost-full with valid held only stalls; a valid gap gives the port away.
        if (!gnt_valid || (accept && (gnt_last || cnt_q == LastCnt))) begin
          state_d = StIdle;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q == StBurst);
  assign overflow     = ovf_q;

`ifdef OTL_FIFO_WR_ARB_STATS_EN
  logic [OTL_STAT_W-1:0] stat_q [N_REQ];
  logic [OTL_STAT_W-1:0] stat_d [N_REQ];
  logic [OTL_STAT_W-1:0] stat_out_q, stat_out_d;

  always_comb begin
    stat_out_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (accept && grant_q == ID_W'(i) && stat_q[i] != '1) begin
        stat_d[i] = stat_q[i] + 1'b1;
      end
      if (stat_sel == ID_W'(i)) stat_out_d = stat_q[i];
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
      stat_out_q <= '0;
    end else begin
      stat_q     <= stat_d;
      stat_out_q <= stat_out_d;
    end
  end

  assign stat_count = stat_out_q;
`endif

endmodule

// File: tb/tb_otl_fifo_wr_arb.sv
// Directed bench for otl_fifo_wr_arb: cycle model, per-requester sequence scoreboard, literal checks.
module tb_otl_fifo_wr_arb;

  localparam int N    = 4;
  localparam int MAXB = 16;
  localparam int BIG  = 32'h7fff_ffff;

  logic            wr_clk = 1'b0;
  logic            reset  = 1'b1;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [32*N-1:0] req_data;
  logic [31:0]     fifo_wr_data;
  logic            fifo_wr_en;
  logic            af     = 1'b0;
  logic            full   = 1'b0;
  logic [1:0]      grant_id;
  logic            busy, overflow;
`ifdef OTL_FIFO_WR_ARB_STATS_EN
  logic [1:0]      stat_sel = 2'd0;
  logic            stat_clr = 1'b0;
  logic [15:0]     stat_count;
`endif

  otl_fifo_wr_arb #(
    .N_REQ     (N),
    .MAX_BURST (MAXB),
    .ID_W      (2)
  ) dut (
    .wr_clk           (wr_clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_almost_full (af),
    .fifo_full        (full),
    .grant_id         (grant_id),
    .busy             (busy),
    .overflow         (overflow)
`ifdef OTL_FIFO_WR_ARB_STATS_EN
    ,
    .stat_sel         (stat_sel),
    .stat_clr         (stat_clr),
    .stat_count       (stat_count)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  // Sources: word payload is {id, running sequence number}; last every src_llen words (0 = never).
  logic src_en   [N] = '{default: 1'b0};
  int   src_llen [N] = '{default: 0};
  int   src_lim  [N] = '{default: BIG};
  int   src_sent [N] = '{default: 0};
  int   src_pos  [N] = '{default: 0};

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = src_en[i] && (src_sent[i] < src_lim[i]);
      req_data[i*32 +: 32] = {8'(i), 24'(src_sent[i])};
      req_last[i]          = (src_llen[i] != 0) && (src_pos[i] == src_llen[i] - 1);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural model
  logic        m_busy    = 1'b0;
  int          m_gid     = 0;
  int          m_ptr     = 0;
  int          m_words   = 0;
  logic        m_wr_en   = 1'b0;
  logic [31:0] m_wr_data = '0;
  logic        m_ovf     = 1'b0;
  int          m_stat [N] = '{default: 0};
  logic [15:0] m_stat_out = '0;

  function automatic int rr_first(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  w;
    bit  acc;
    acc = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_words = 0;
      m_wr_en = 1'b0; m_wr_data = '0; m_ovf = 1'b0; m_stat_out = '0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
      return;
    end
    m_ovf = m_ovf | (m_wr_en & full);
`ifdef OTL_FIFO_WR_ARB_STATS_EN
    m_stat_out = 16'(m_stat[stat_sel]);
`endif
    if (!m_busy) begin
      m_wr_en = 1'b0;
      w = rr_first(req_valid, m_ptr);
      if (w >= 0 && !af) begin
        m_gid = w; m_busy = 1'b1; m_words = 0;
      end
    end else begin
      acc     = req_valid[m_gid] && !af;
      m_wr_en = acc;
      if (acc) begin
        m_wr_data = req_data[m_gid*32 +: 32];
        m_words++;
      end
      if (!req_valid[m_gid] || (acc && (req_last[m_gid] || m_words == MAXB))) begin
        m_busy = 1'b0;
        m_ptr  = (m_gid + 1) % N;
      end
    end
`ifdef OTL_FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      if (stat_clr) m_stat[i] = 0;
      else if (acc && i == m_gid && m_stat[i] < 65535) m_stat[i]++;
    end
`endif
  endtask

  // Per-cycle snapshot and logs of grant activity
  logic [N-1:0] hs, hs_last;
  logic         s_busy, s_wr_en, s_ovf;
  logic [N-1:0] s_ready;
  logic [1:0]   s_grant;
  logic [15:0]  s_stat;
  int           exp_seq [N] = '{default: 0};
  int           grant_log[$];
  int           len_log[$];
  int           gap_log[$];
  logic         prev_busy = 1'b0;
  int           run = 0;
  int           idle = 0;

  task automatic compare();
    logic [N-1:0] e_ready;
    int           id;
    hs      = req_valid & req_ready;
    hs_last = req_last;
    s_busy  = busy; s_wr_en = fifo_wr_en; s_ovf = overflow; s_ready = req_ready; s_grant = grant_id;
    s_stat  = '0;
`ifdef OTL_FIFO_WR_ARB_STATS_EN
    s_stat  = stat_count;
`endif
    if (reset) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_stat", 32'(s_stat), 0);
      prev_busy = 1'b0; run = 0; idle = 0;
      return;
    end
    e_ready = '0;
    if (m_busy && !af) e_ready[m_gid] = 1'b1;
    chk("ready", 32'(req_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_busy) chk("grant", 32'(grant_id), 32'(m_gid));
    chk("wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
    chk("wr_data", fifo_wr_data, m_wr_data);
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef OTL_FIFO_WR_ARB_STATS_EN
    chk("stat_count", 32'(stat_count), 32'(m_stat_out));
`endif
    if (fifo_wr_en) begin
      id = int'(fifo_wr_data[31:24]);
      if (id < N) begin
        chk("seq", 32'(fifo_wr_data[23:0]), 32'(24'(exp_seq[id])));
        exp_seq[id]++;
      end else begin
        chk("seq_id", 32'(id), 0);
      end
    end
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_id));
      gap_log.push_back(idle);
      run = 0;
    end
    if (!busy && prev_busy) begin
      len_log.push_back(run);
      idle = 0;
    end
    if (busy) run++;
    else idle++;
    prev_busy = busy;
  endtask

  task automatic cycle();
    @(negedge wr_clk);
    compare();
    @(posedge wr_clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        src_sent[i]++;
        src_pos[i] = hs_last[i] ? 0 : src_pos[i] + 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic all_off();
    for (int i = 0; i < N; i++) begin
      src_en[i] = 1'b0; src_llen[i] = 0; src_lim[i] = BIG;
    end
    repeat (4) cycle();
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  initial begin
    int first, nwr, nbusy, nrdy_lo, gb, lb, xb;
    int lim1;
    do_reset();

    // Single requester, 5-word burst ending in last
    src_llen[0] = 5; src_lim[0] = src_sent[0] + 5; src_en[0] = 1'b1;
    first = -1; nwr = 0; nbusy = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_wr_en) begin nwr++; if (first < 0) first = k; end
      if (s_busy) nbusy++;
    end
    chk("t1_words", 32'(nwr), 5);
    chk("t1_latency", 32'(first), 2);
    chk("t1_busy_cycles", 32'(nbusy), 5);
    all_off();

    // All four continuously valid: 16-word bursts, grants 0,1,2,3,0, one idle between
    do_reset();
    gb = grant_log.size(); lb = len_log.size(); xb = gap_log.size();
    for (int i = 0; i < N; i++) src_en[i] = 1'b1;
    repeat (75) cycle();
    all_off();
    chk("t2_grant0", 32'(qget(grant_log, gb)), 0);
    chk("t2_grant1", 32'(qget(grant_log, gb + 1)), 1);
    chk("t2_grant2", 32'(qget(grant_log, gb + 2)), 2);
    chk("t2_grant3", 32'(qget(grant_log, gb + 3)), 3);
    chk("t2_grant4", 32'(qget(grant_log, gb + 4)), 0);
    for (int k = 0; k < 4; k++) chk("t2_burst_len", 32'(qget(len_log, lb + k)), 16);
    for (int k = 1; k < 4; k++) chk("t2_idle_gap", 32'(qget(gap_log, xb + k)), 1);

    // Almost-full for 10 cycles mid-burst
    do_reset();
    src_en[1] = 1'b1;
    repeat (4) cycle();
    af = 1'b1;
    nwr = 0; nbusy = 0; nrdy_lo = 0;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (s_wr_en) nwr++;
      if (s_busy) nbusy++;
      if (s_busy && s_ready == '0) nrdy_lo++;
      if (k == 9) af = 1'b0;
    end
    chk("t3_busy_held", 32'(nbusy), 14);
    chk("t3_ready_low", 32'(nrdy_lo), 10);
    chk("t3_writes", 32'(nwr), 4);
    chk("t3_grant", 32'(s_grant), 1);
    all_off();

    // Requester 2 gaps after 3 words; pointer moves to 3 ahead of a pending 0
    do_reset();
    gb = grant_log.size(); lb = len_log.size();
    src_en[2] = 1'b1; src_lim[2] = src_sent[2] + 3;
    src_en[3] = 1'b1;
    cycle();
    src_en[0] = 1'b1;
    repeat (8) cycle();
    all_off();
    chk("t4_first_grant", 32'(qget(grant_log, gb)), 2);
    chk("t4_second_grant", 32'(qget(grant_log, gb + 1)), 3);
    chk("t4_release_len", 32'(qget(len_log, lb)), 4);

    // fifo_full while a write is presented
    do_reset();
    src_en[0] = 1'b1;
    repeat (3) cycle();
    full = 1'b1;
    cycle();
    full = 1'b0;
    repeat (3) cycle();
    chk("t5_overflow_set", 32'(s_ovf), 1);
    all_off();
    chk("t5_overflow_sticky", 32'(s_ovf), 1);
    do_reset();
    cycle();
    chk("t5_overflow_reset", 32'(s_ovf), 0);

`ifdef OTL_FIFO_WR_ARB_STATS_EN
    // Saturation and clear of requester 1 counter
    src_en[1] = 1'b1;
    lim1 = src_sent[1] + 70000;
    src_lim[1] = lim1;
    for (int k = 0; k < 80000 && src_sent[1] < lim1; k++) cycle();
    chk("t6_words_sent", 32'(src_sent[1] >= lim1), 1);
    all_off();
    stat_sel = 2'd1;
    repeat (2) cycle();
    chk("t6_stat_sat", 32'(s_stat), 32'hffff);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    repeat (2) cycle();
    chk("t6_stat_clr", 32'(s_stat), 0);
`else
    lim1 = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/otl_fifo_wr_arb.md
# otl_fifo_wr_arb

Round-robin write-port arbiter sharing one 32-bit dual-clock FIFO write port among N requesters in the write-clock domain. Each requester gets a valid/ready burst interface. The arbiter grants one requester at a time for a bounded burst and drives a registered `fifo_wr_en`/`fifo_wr_data` into the FIFO. It throttles on the FIFO's almost-full flag and flags any write issued while the FIFO is full.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `MAX_BURST`, default 16: maximum words per grant (1..256).
- `ID_W`, default 2: width of grant ID, equal to clog2(N_REQ).

Ports:
- `wr_clk`, in, 1: single clock; the FIFO write clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, N_REQ: per-requester word valid.
- `req_data`, in, 32*N_REQ: requester i occupies bits [32i+31:32i].
- `req_last`, in, N_REQ: marks the final word of a requester's burst.
- `req_ready`, out, N_REQ: word accepted when valid and ready are both high.
- `fifo_wr_data`, out, 32: registered write data.
- `fifo_wr_en`, out, 1: registered write enable.
- `fifo_almost_full`, in, 1: FIFO programmable almost-full flag.
- `fifo_full`, in, 1: FIFO full flag.
- `grant_id`, out, ID_W: currently granted requester; valid while `busy`.
- `busy`, out, 1: high in BURST state.
- `overflow`, out, 1: sticky; set when a write was issued against a full FIFO.
- `stat_sel`, in, ID_W: statistics counter select (present only with stats).
- `stat_clr`, in, 1: clears all statistics counters (present only with stats).
- `stat_count`, out, 16: word count of requester `stat_sel` (present only with stats).

## Operation
- FSM states are IDLE and BURST. Reset state is IDLE.
- IDLE:
  - All `req_ready` are low.
  - If any `req_valid` is high and `fifo_almost_full` is low, choose the first valid requester searching upward from `rr_ptr`, wrapping modulo N_REQ.
  - Register the winner into `grant_id`, clear `burst_cnt`, and go to BURST.
- BURST:
  - `req_ready[grant_id]` = !`fifo_almost_full`. All other ready bits are low.
  - On acceptance, the word and `1` are registered into `fifo_wr_data`/`fifo_wr_en` on the next edge, and `burst_cnt` increments.
  - Return to IDLE with `rr_ptr` = `grant_id`+1 (mod N_REQ) on any of:
    - an accepted word with `req_last` high;
    - an accepted word with `burst_cnt` == MAX_BURST-1;
    - a BURST cycle in which `req_valid[grant_id]` is low (a gap releases the grant).
  - `fifo_almost_full` high with valid high does not release the grant; the requester stalls.
- `fifo_wr_en` is low in every cycle that did not follow an acceptance. `fifo_wr_data` holds its last value when not writing.
- `overflow` is set when `fifo_wr_en` and `fifo_full` are both high. It clears only on reset. The write is still presented; the FIFO drops it.
- `burst_cnt` is 8 bits wide and compares against MAX_BURST-1. It never wraps because the grant ends at MAX_BURST.
- Reset mid-burst: the in-flight registered word is discarded (`fifo_wr_en` goes low asynchronously), and the arbiter returns to IDLE with `rr_ptr` = 0.

Reset values: `req_ready` 0, `fifo_wr_en` 0, `fifo_wr_data` 0, `grant_id` 0, `busy` 0, `overflow` 0, `stat_count` 0.

## Timing
- Arbitration latency: `req_valid` rises at cycle t in IDLE → `busy`/`grant_id` at t+1 → first acceptance at t+1 → `fifo_wr_en` at t+2.
- Throughput is 1 word/cycle within a burst, with exactly one IDLE cycle between bursts.
- `req_ready` is combinational from state, `grant_id` and `fifo_almost_full`. It has no path from `req_valid`.
- Write-path latency is exactly 1 cycle. Almost-full offset (128 words) ≫ 1, so the arbiter never overflows a correctly configured FIFO.

## Configuration
- `OTL_FIFO_WR_ARB_STATS_EN` defined: per-requester 16-bit word counters.
  - Each counter increments on acceptance and saturates at 0xFFFF.
  - `stat_clr` zeroes all counters synchronously; clear wins over a simultaneous increment.
  - `stat_count` is a registered mux of the counter selected by `stat_sel`, with 1-cycle latency.
- Macro undefined: the counters and the `stat_*` ports are removed; the arbitration behaviour is identical.

## Structure
- Shared package `otl_pkg` holds:
  - the FSM state enum (IDLE, BURST);
  - the data-width constant `OTL_DATA_W` = 32;
  - the statistics counter width `OTL_STAT_W` = 16.
- Sub-module `otl_rr_pick`: combinational round-robin priority picker with inputs request vector and pointer, outputs winner index and any-valid.

## Test plan
- Single requester 0, burst of 5 words with `last` on word 5 → 5 consecutive `fifo_wr_en` starting 2 cycles after valid; `busy` drops after word 5.
- All 4 requesters continuously valid, no last, MAX_BURST=16 → grants cycle 0,1,2,3,0 with 16 words each and one idle cycle between grants.
- `fifo_almost_full` raised mid-burst for 10 cycles → `req_ready` low for those 10 cycles, no `fifo_wr_en` gaps beyond them, grant retained, no data lost or duplicated.
- Requester 2 drops valid mid-burst after 3 words → grant released next cycle and `rr_ptr` = 3; a pending requester 3 is granted next.
- Force `fifo_full` high while a word is in flight → `overflow` goes to 1 and stays 1; only `reset` clears it.
- With `OTL_FIFO_WR_ARB_STATS_EN`: 70000 words from requester 1 → `stat_count` = 0xFFFF with `stat_sel`=1; `stat_clr` → 0.
